lock_ctrl: RTL and testbench

LOCK_CTRL -- requirements
Module: lock_ctrl

---
 rtl/lock_ctrl_if.sv | 45 ++++
 rtl/lock_ctrl.sv | 164 ++++++++++++++++
 tb/tb_lock_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lock_ctrl_if
// Description : User-side bundle of the lock controller. Carries the panel
//               switches, the submit key, the digit-counter value and all
//               status/indicator outputs.
//   master : panel/display side (drives switches, key, digits)
//   slave  : lock_ctrl (drives counter controls and indicators)
//   enter_req  1  level, request password entry
//   set_req    1  level, request password change
//   confirm    1  level, debounced submit key
//   digits     16 four BCD digits, [3:0] rightmost
//   cnt_start  1  enables digit counters
//   cnt_clr    1  clears digit counters
//   open       1  lock-open indicator
//   lock       1  lockout indicator
//   countdown  6  seconds remaining in timed states
//   tries_left 2  attempts remaining
//   state_code 3  IDLE=0 ENTRY=1 OPEN=2 SETPW=3 LOCKOUT=4
// Revision    : 1.0 - initial release
// ============================================================================
interface lock_ctrl_if;
    logic        enter_req;
    logic        set_req;
    logic        confirm;
    logic [15:0] digits;
    logic        cnt_start;
    logic        cnt_clr;
    logic        open;
    logic        lock;
    logic [5:0]  countdown;
    logic [1:0]  tries_left;
    logic [2:0]  state_code;

    modport master (
        output enter_req, set_req, confirm, digits,
        input  cnt_start, cnt_clr, open, lock, countdown, tries_left, state_code
    );

    modport slave (
        input  enter_req, set_req, confirm, digits,
        output cnt_start, cnt_clr, open, lock, countdown, tries_left, state_code
    );
endinterface
`default_nettype wire

// File: rtl/lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lock_ctrl
// Description : Password lock controller. Entry window with timeout, limited
//               attempts followed by a timed lockout, and password change
//               while open. One-second ticks come from an internal divider.
//   clk    1  system clock, rising edge
//   reset  1  asynchronous active-low reset
//   bus    lock_ctrl_if.slave (switches, key, digits in; indicators out)
// Revision    : 1.0 - initial release
// ============================================================================
module lock_ctrl #(
    parameter int TICK_DIV  = 100000000,
    parameter int TIMEOUT_S = 10,
    parameter int LOCKOUT_S = 30,
    parameter int MAX_TRIES = 3
) (
    input  logic        clk,
    input  logic        reset,
    lock_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_OPEN    = 3'd2,
        S_SETPW   = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    localparam int               DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [5:0]       TIMEOUT_CD = 6'(TIMEOUT_S);
    localparam logic [5:0]       LOCKOUT_CD = 6'(LOCKOUT_S);
    localparam logic [1:0]       TRIES_INIT = 2'(MAX_TRIES);

    state_t             state, state_nx;
    logic [15:0]        pw, pw_nx;
    logic [5:0]         countdown, countdown_nx;
    logic [1:0]         tries, tries_nx;
    logic [DIV_W-1:0]   div;
    logic               conf_q, conf_prev;
    logic               clr_pulse, clr_pulse_nx;
    logic               reload;
    logic               restart;
    logic               conf_event;
    logic               tick;

    assign conf_event = conf_q & ~conf_prev;
    assign tick       = (div == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            pw        <= 16'h0000;
            countdown <= 6'd0;
            tries     <= TRIES_INIT;
            div       <= '0;
            conf_q    <= 1'b0;
            conf_prev <= 1'b0;
            clr_pulse <= 1'b0;
        end else begin
            state     <= state_nx;
            pw        <= pw_nx;
            countdown <= countdown_nx;
            tries     <= tries_nx;
            // divider restarts so every timed window gets full-length seconds
            div       <= (restart || tick) ? '0 : div + DIV_ONE;
            conf_q    <= bus.confirm;
            conf_prev <= conf_q;
            clr_pulse <= clr_pulse_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        pw_nx        = pw;
        countdown_nx = countdown;
        tries_nx     = tries;
        clr_pulse_nx = 1'b0;
        reload       = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.enter_req && !bus.set_req) begin
                    state_nx     = S_ENTRY;
                    countdown_nx = TIMEOUT_CD;
                end
            end
            S_ENTRY: begin
                // abandoning entry wins over confirm, which wins over timeout
                if (!bus.enter_req) begin
                    state_nx     = S_IDLE;
                    countdown_nx = 6'd0;
                end else if (conf_event) begin
                    if (bus.digits == pw) begin
                        state_nx     = S_OPEN;
                        tries_nx     = TRIES_INIT;
                        countdown_nx = 6'd0;
                    end else if (tries > 2'd1) begin
                        tries_nx     = tries - 2'd1;
                        clr_pulse_nx = 1'b1;
                        countdown_nx = TIMEOUT_CD;
                        reload       = 1'b1;
                    end else begin
                        state_nx     = S_LOCKOUT;
                        tries_nx     = 2'd0;
                        countdown_nx = LOCKOUT_CD;
                    end
                end else if (tick) begin
                    if (countdown <= 6'd1) begin
                        state_nx     = S_LOCKOUT;
                        countdown_nx = LOCKOUT_CD;
                    end else begin
                        countdown_nx = countdown - 6'd1;
                    end
                end
            end
            S_OPEN: begin
                if (bus.set_req) begin
                    state_nx = S_SETPW;
                end else if (!bus.enter_req) begin
                    state_nx = S_IDLE;
                end
            end
            S_SETPW: begin
                if (conf_event) begin
                    pw_nx    = bus.digits;
                    state_nx = S_OPEN;
                end else if (!bus.set_req) begin
                    state_nx = S_OPEN;
                end
            end
            S_LOCKOUT: begin
                if (tick) begin
                    if (countdown <= 6'd1) begin
                        state_nx     = S_IDLE;
                        tries_nx     = TRIES_INIT;
                        countdown_nx = 6'd0;
                    end else begin
                        countdown_nx = countdown - 6'd1;
                    end
                end
            end
            default: begin
                state_nx     = S_IDLE;
                countdown_nx = 6'd0;
            end
        endcase

        restart = reload || (state_nx != state);
    end

    assign bus.cnt_start  = (state == S_ENTRY) || (state == S_SETPW);
    assign bus.cnt_clr    = (state == S_IDLE) || (state == S_LOCKOUT) || clr_pulse;
    assign bus.open       = (state == S_OPEN) || (state == S_SETPW);
    assign bus.lock       = (state == S_LOCKOUT);
    assign bus.countdown  = countdown;
    assign bus.tries_left = tries;
    assign bus.state_code = state;

endmodule
`default_nettype wire

// File: tb/tb_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lock_ctrl
// Description : Self-checking bench for lock_ctrl. A cycle-level behavioural
//               model (seconds counter, attempt count, phase-within-second)
//               is compared against every output on each falling edge;
//               directed scenarios pin the model with literal values, then
//               randomized switch/key/digit traffic runs against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_ctrl;
    localparam int TD = 4;
    localparam int TO = 10;
    localparam int LO = 30;
    localparam int MT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lock_ctrl_if bus();

    lock_ctrl #(
        .TICK_DIV  (TD),
        .TIMEOUT_S (TO),
        .LOCKOUT_S (LO),
        .MAX_TRIES (MT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // model: 0 idle, 1 entry, 2 open, 3 setpw, 4 lockout
    int          m_state;
    int          m_cd;
    int          m_tries;
    int          m_phase;
    logic [15:0] m_pw;
    bit          m_cq, m_cp, m_clr;
    bit          cmp_en = 1'b0;

    function void model_reset();
        m_state = 0; m_pw = 16'h0000; m_cd = 0; m_tries = MT;
        m_phase = 0; m_cq = 0; m_cp = 0; m_clr = 0;
    endfunction

    function void model_step();
        bit ev;
        bit tick;
        bit rs;
        int ns;
        if (!reset) begin
            model_reset();
            return;
        end
        ev    = m_cq && !m_cp;
        tick  = (m_phase % TD) == (TD - 1);
        ns    = m_state;
        rs    = 0;
        m_clr = 0;
        case (m_state)
            0: if (bus.enter_req && !bus.set_req) begin ns = 1; m_cd = TO; end
            1: begin
                if (!bus.enter_req) begin
                    ns = 0; m_cd = 0;
                end else if (ev) begin
                    if (bus.digits == m_pw) begin
                        ns = 2; m_tries = MT; m_cd = 0;
                    end else if (m_tries > 1) begin
                        m_tries = m_tries - 1; m_clr = 1; m_cd = TO; rs = 1;
                    end else begin
                        ns = 4; m_tries = 0; m_cd = LO;
                    end
                end else if (tick) begin
                    m_cd = m_cd - 1;
                    if (m_cd == 0) begin ns = 4; m_cd = LO; end
                end
            end
            2: if (bus.set_req) ns = 3; else if (!bus.enter_req) ns = 0;
            3: if (ev) begin m_pw = bus.digits; ns = 2; end
               else if (!bus.set_req) ns = 2;
            4: if (tick) begin
                m_cd = m_cd - 1;
                if (m_cd == 0) begin ns = 0; m_tries = MT; end
            end
            default: ns = 0;
        endcase
        if (ns != m_state || rs) m_phase = 0;
        else m_phase = m_phase + 1;
        m_state = ns;
        m_cp = m_cq;
        m_cq = bus.confirm;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // every cycle: all outputs versus the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_state_code", int'(bus.state_code), m_state);
            chk("m_countdown",  int'(bus.countdown),  m_cd);
            chk("m_tries_left", int'(bus.tries_left), m_tries);
            chk("m_cnt_start",  int'(bus.cnt_start),  int'(m_state == 1 || m_state == 3));
            chk("m_cnt_clr",    int'(bus.cnt_clr),    int'(m_state == 0 || m_state == 4 || m_clr));
            chk("m_open",       int'(bus.open),       int'(m_state == 2 || m_state == 3));
            chk("m_lock",       int'(bus.lock),       int'(m_state == 4));
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic press();
        bus.confirm = 1'b1;
        cyc(1);
        bus.confirm = 1'b0;
        cyc(1);
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("arst_lock",  int'(bus.lock),       0);
        chk("arst_state", int'(bus.state_code), 0);
        chk("arst_clr",   int'(bus.cnt_clr),    1);
        chk("arst_open",  int'(bus.open),       0);
        cyc(2);
        reset = 1'b1;
    endtask

    initial begin
        int r;
        reset         = 1'b0;
        bus.enter_req = 1'b0;
        bus.set_req   = 1'b0;
        bus.confirm   = 1'b0;
        bus.digits    = 16'h0000;
        model_reset();
        cmp_en = 1'b1;
        cyc(3);
        chk("rst_state", int'(bus.state_code), 0);
        chk("rst_clr",   int'(bus.cnt_clr),    1);
        chk("rst_start", int'(bus.cnt_start),  0);
        chk("rst_open",  int'(bus.open),       0);
        chk("rst_tries", int'(bus.tries_left), 3);
        chk("rst_cd",    int'(bus.countdown),  0);
        reset = 1'b1;
        cyc(1);

        // open with the reset password
        bus.enter_req = 1'b1;
        cyc(1);
        chk("entry_state", int'(bus.state_code), 1);
        chk("entry_cd",    int'(bus.countdown),  10);
        chk("entry_start", int'(bus.cnt_start),  1);
        bus.digits = 16'h0000;
        press();
        chk("open_state", int'(bus.state_code), 2);
        chk("open_open",  int'(bus.open),       1);
        chk("open_tries", int'(bus.tries_left), 3);
        chk("open_cd",    int'(bus.countdown),  0);

        // change password to 1234, then relock
        bus.set_req = 1'b1;
        cyc(1);
        chk("setpw_state", int'(bus.state_code), 3);
        bus.digits = 16'h1234;
        press();
        chk("setpw_back_open", int'(bus.state_code), 2);
        bus.set_req   = 1'b0;
        bus.enter_req = 1'b0;
        cyc(1);
        chk("relock_state", int'(bus.state_code), 0);
        chk("relock_open",  int'(bus.open),       0);

        // three wrong attempts -> lockout -> recovery
        bus.enter_req = 1'b1;
        cyc(1);
        bus.digits = 16'h1111;
        press();
        chk("wrong1_tries", int'(bus.tries_left), 2);
        chk("wrong1_clr",   int'(bus.cnt_clr),    1);
        chk("wrong1_cd",    int'(bus.countdown),  10);
        cyc(1);
        chk("wrong1_clr_end", int'(bus.cnt_clr), 0);
        press();
        chk("wrong2_tries", int'(bus.tries_left), 1);
        press();
        chk("wrong3_state", int'(bus.state_code), 4);
        chk("wrong3_lock",  int'(bus.lock),       1);
        chk("wrong3_cd",    int'(bus.countdown),  30);
        chk("wrong3_tries", int'(bus.tries_left), 0);
        bus.enter_req = 1'b0;
        cyc(30 * TD - 1);
        chk("lock_last_state", int'(bus.state_code), 4);
        chk("lock_last_cd",    int'(bus.countdown),  1);
        cyc(1);
        chk("unlock_state", int'(bus.state_code), 0);
        chk("unlock_tries", int'(bus.tries_left), 3);

        // password 1234 still opens
        bus.enter_req = 1'b1;
        cyc(1);
        bus.digits = 16'h1234;
        press();
        chk("pw1234_open", int'(bus.state_code), 2);
        bus.enter_req = 1'b0;
        cyc(1);

        // entry timeout after exactly 40 cycles
        bus.enter_req = 1'b1;
        cyc(1);
        cyc(4);
        chk("to_cd9", int'(bus.countdown), 9);
        cyc(35);
        chk("to_last_state", int'(bus.state_code), 1);
        chk("to_last_cd",    int'(bus.countdown),  1);
        cyc(1);
        chk("to_lock_state", int'(bus.state_code), 4);
        chk("to_lock_cd",    int'(bus.countdown),  30);
        bus.enter_req = 1'b0;

        // asynchronous reset in the middle of lockout
        cyc(5);
        async_reset();
        cyc(1);
        chk("post_rst_state", int'(bus.state_code), 0);
        chk("post_rst_tries", int'(bus.tries_left), 3);

        // correct confirm coincides with final tick; pw must be back to 0000
        bus.enter_req = 1'b1;
        cyc(1);
        cyc(38);
        bus.digits  = 16'h0000;
        bus.confirm = 1'b1;
        cyc(1);
        chk("race_pre_state", int'(bus.state_code), 1);
        chk("race_pre_cd",    int'(bus.countdown),  1);
        bus.confirm = 1'b0;
        cyc(1);
        chk("race_open",  int'(bus.state_code), 2);
        chk("race_lock",  int'(bus.lock),       0);
        chk("race_tries", int'(bus.tries_left), 3);
        bus.enter_req = 1'b0;
        cyc(1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bus.enter_req = ($urandom_range(0, 15) != 0);
            bus.set_req   = ($urandom_range(0, 9) == 0);
            bus.confirm   = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 3);
            case (r)
                0:       bus.digits = m_pw;
                1:       bus.digits = 16'h1111;
                2:       bus.digits = 16'h0000;
                default: bus.digits = 16'($urandom);
            endcase
            if ($urandom_range(0, 499) == 0) async_reset();
            else cyc(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
